// File: rtl/wb_pkg.sv
// Write-back selector shared definitions.
// Source indices are shared with the control unit.
package wb_pkg;

   localparam int WB_WIDTH   = 32;
   localparam int WB_N_SRC   = 8;
   localparam int WB_TIMEOUT = 15;

   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_MDR = 1;
   localparam int WB_SRC_SHF = 2;
   localparam int WB_SRC_HI  = 3;
   localparam int WB_SRC_LO  = 4;
   localparam int WB_SRC_PC4 = 5;
   localparam int WB_SRC_IMM = 6;
   localparam int WB_SRC_LUI = 7;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_src_mux.sv
// N_SRC:1 data/valid selector.
// Out-of-range indices fall to the last source.
module wb_src_mux #(
   parameter int WIDTH = 32,
   parameter int N_SRC = 8,
   parameter int SEL_W = 3
) (
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic [N_SRC-1:0]       src_valid,
   input  logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       data,
   output logic                   valid
);

   int idx;

   always_comb begin
      idx = int'(sel);
      if (idx >= N_SRC) idx = N_SRC - 1;
   end

   always_comb begin
      data  = '0;
      valid = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (k == idx) begin
            data  = src_data[k*WIDTH +: WIDTH];
            valid = src_valid[k];
         end
      end
   end

endmodule

// File: rtl/wb_select_unit.sv
// Write-back source selector with capture handshake
// and timeout abort toward the register bank.
module wb_select_unit
   import wb_pkg::*;
#(
   parameter int WIDTH   = WB_WIDTH,
   parameter int N_SRC   = WB_N_SRC,
   parameter int SEL_W   = $clog2(N_SRC),
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [SEL_W-1:0]       sel,
   input  logic                   flush,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic [N_SRC-1:0]       src_valid,
   output logic                   busy,
   output logic [WIDTH-1:0]       wb_data,
   output logic                   wb_valid,
   output logic                   timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wb_state_t        state;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] mux_sel;
   logic [WIDTH-1:0] mux_data;
   logic             mux_valid;

   // IDLE looks at the live select, WAIT at the latched one.
   assign mux_sel = (state == WB_WAIT) ? sel_q : sel;

   wb_src_mux #(
      .WIDTH(WIDTH),
      .N_SRC(N_SRC),
      .SEL_W(SEL_W)
   ) u_mux (
      .src_data(src_data),
      .src_valid(src_valid),
      .sel(mux_sel),
      .data(mux_data),
      .valid(mux_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WB_IDLE;
         sel_q       <= '0;
         cnt         <= '0;
         wb_data     <= '0;
         wb_valid    <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         wb_valid    <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            WB_IDLE: begin
               if (start && !flush) begin
                  sel_q <= sel;
                  if (mux_valid) begin
                     wb_data  <= mux_data;
                     wb_valid <= 1'b1;
                  end else begin
                     state <= WB_WAIT;
                     busy  <= 1'b1;
                     cnt   <= '0;
                  end
               end
            end
            WB_WAIT: begin
               if (flush) begin
                  state <= WB_IDLE;
                  busy  <= 1'b0;
               end else if (mux_valid) begin
                  wb_data  <= mux_data;
                  wb_valid <= 1'b1;
                  state    <= WB_IDLE;
                  busy     <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= WB_IDLE;
                  busy        <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= WB_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit: default
// 8-source instance plus a 5-source instance.
module tb_wb_select_unit;

   logic clk = 1'b0;
   logic reset;

   logic          a_start, a_flush;
   logic [2:0]    a_sel;
   logic [255:0]  a_src;
   logic [7:0]    a_vld;
   logic          a_busy, a_wbv, a_terr;
   logic [31:0]   a_data;

   logic          b_start, b_flush;
   logic [2:0]    b_sel;
   logic [159:0]  b_src;
   logic [4:0]    b_vld;
   logic          b_busy, b_wbv, b_terr;
   logic [31:0]   b_data;

   int checks = 0;
   int failures = 0;
   int pulses;

   always #5 clk = ~clk;

   wb_select_unit u_a (
      .clk(clk), .reset(reset), .start(a_start), .sel(a_sel),
      .flush(a_flush), .src_data(a_src), .src_valid(a_vld),
      .busy(a_busy), .wb_data(a_data), .wb_valid(a_wbv),
      .timeout_err(a_terr)
   );

   wb_select_unit #(
      .WIDTH(32), .N_SRC(5), .SEL_W(3), .TIMEOUT(15)
   ) u_b (
      .clk(clk), .reset(reset), .start(b_start), .sel(b_sel),
      .flush(b_flush), .src_data(b_src), .src_valid(b_vld),
      .busy(b_busy), .wb_data(b_data), .wb_valid(b_wbv),
      .timeout_err(b_terr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      a_start = 0; a_flush = 0; a_sel = 0; a_src = '0; a_vld = '0;
      b_start = 0; b_flush = 0; b_sel = 0; b_src = '0; b_vld = '0;
      step();
      step();
      reset = 1'b0;
      chk("rst_data", a_data, 32'h0);
      chk("rst_valid", {31'b0, a_wbv}, 32'h0);
      chk("rst_busy", {31'b0, a_busy}, 32'h0);
      chk("rst_terr", {31'b0, a_terr}, 32'h0);

      // 1: immediate capture
      a_src[1*32 +: 32] = 32'hDEADBEEF;
      a_vld = 8'h02; a_sel = 3'd1; a_start = 1;
      step();
      a_start = 0;
      chk("imm_valid", {31'b0, a_wbv}, 32'h1);
      chk("imm_data", a_data, 32'hDEADBEEF);
      chk("imm_busy", {31'b0, a_busy}, 32'h0);
      step();
      chk("imm_pulse_end", {31'b0, a_wbv}, 32'h0);

      // 2: delayed valid, 4 busy cycles
      a_vld = 8'h00; a_src[1*32 +: 32] = 32'h12345678;
      a_sel = 3'd1; a_start = 1;
      step();
      a_start = 0;
      for (int i = 1; i <= 4; i++) begin
         chk("dly_busy", {31'b0, a_busy}, 32'h1);
         chk("dly_novalid", {31'b0, a_wbv}, 32'h0);
         if (i == 4) a_vld = 8'h02;
         step();
      end
      chk("dly_valid", {31'b0, a_wbv}, 32'h1);
      chk("dly_data", a_data, 32'h12345678);
      chk("dly_busy_off", {31'b0, a_busy}, 32'h0);
      a_vld = 8'h00;
      step();
      chk("dly_pulse_end", {31'b0, a_wbv}, 32'h0);

      // 3: timeout after 15 WAIT cycles
      a_sel = 3'd3; a_start = 1;
      step();
      a_start = 0;
      pulses = 0;
      for (int i = 1; i <= 15; i++) begin
         if (a_terr || !a_busy || a_wbv) pulses++;
         step();
      end
      chk("to_early", pulses, 32'd0);
      chk("to_terr", {31'b0, a_terr}, 32'h1);
      chk("to_novalid", {31'b0, a_wbv}, 32'h0);
      chk("to_busy", {31'b0, a_busy}, 32'h0);
      chk("to_data_kept", a_data, 32'h12345678);
      step();
      chk("to_pulse_end", {31'b0, a_terr}, 32'h0);

      // 4: flush on 3rd WAIT cycle
      a_sel = 3'd2; a_src[2*32 +: 32] = 32'hCAFEF00D; a_start = 1;
      step();
      a_start = 0;
      step();
      step();
      a_flush = 1;
      step();
      a_flush = 0;
      chk("fl_busy", {31'b0, a_busy}, 32'h0);
      a_vld = 8'h04;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_wbv || a_terr) pulses++;
         step();
      end
      chk("fl_no_pulse", pulses, 32'd0);
      chk("fl_data_kept", a_data, 32'h12345678);
      // flush in IDLE blocks a start
      a_start = 1; a_flush = 1;
      step();
      a_start = 0; a_flush = 0;
      chk("fl_idle_block", {31'b0, a_wbv}, 32'h0);
      chk("fl_idle_busy", {31'b0, a_busy}, 32'h0);

      // back-to-back starts across a wb_valid pulse
      a_src[0*32 +: 32] = 32'h00000111;
      a_src[6*32 +: 32] = 32'h00000666;
      a_vld = 8'h41; a_sel = 3'd0; a_start = 1;
      step();
      chk("b2b_first", a_data, 32'h00000111);
      a_sel = 3'd6;
      step();
      a_start = 0;
      chk("b2b_valid", {31'b0, a_wbv}, 32'h1);
      chk("b2b_second", a_data, 32'h00000666);

      // 5: reset mid-WAIT
      a_vld = 8'h00; a_sel = 3'd5; a_start = 1;
      step();
      a_start = 0;
      step();
      chk("rw_busy", {31'b0, a_busy}, 32'h1);
      reset = 1;
      step();
      reset = 0;
      chk("rw_busy0", {31'b0, a_busy}, 32'h0);
      chk("rw_data0", a_data, 32'h0);
      chk("rw_valid0", {31'b0, a_wbv}, 32'h0);
      chk("rw_terr0", {31'b0, a_terr}, 32'h0);
      a_src[5*32 +: 32] = 32'h55555555;
      a_vld = 8'h20;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (a_wbv || a_terr) pulses++;
         step();
      end
      chk("rw_no_pulse", pulses, 32'd0);
      a_vld = 8'h00;

      // 6: N_SRC=5, sel=7 clamps to source 4
      b_src[4*32 +: 32] = 32'hA5A5A5A5;
      b_src[0*32 +: 32] = 32'h0BADBAD0;
      b_sel = 3'd7; b_start = 1;
      step();
      chk("n5_busy", {31'b0, b_busy}, 32'h1);
      b_sel = 3'd0; b_vld = 5'b00001;
      step();
      step();
      b_start = 0;
      chk("n5_ignore", {31'b0, b_wbv}, 32'h0);
      b_vld = 5'b10001;
      pulses = 0;
      step();
      chk("n5_valid", {31'b0, b_wbv}, 32'h1);
      chk("n5_data", b_data, 32'hA5A5A5A5);
      b_vld = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         step();
         if (b_wbv || b_busy) pulses++;
      end
      chk("n5_one_pulse", pulses, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
